// File: rtl/vga_timing_pkg.sv
// Shared 640x480@60Hz timing constants and the phase encoding used by both line/frame FSMs.
package vga_timing_pkg;

  localparam int unsigned DIV_DEFAULT = 4;

  localparam int unsigned H_ACT        = 640;
  localparam int unsigned H_FP         = 16;
  localparam int unsigned H_SYNC       = 96;
  localparam int unsigned H_BP         = 48;
  localparam int unsigned H_TOTAL      = H_ACT + H_FP + H_SYNC + H_BP;
  localparam int unsigned H_SYNC_START = H_ACT + H_FP;
  localparam int unsigned H_SYNC_END   = H_SYNC_START + H_SYNC;

  localparam int unsigned V_ACT        = 480;
  localparam int unsigned V_FP         = 10;
  localparam int unsigned V_SYNC       = 2;
  localparam int unsigned V_BP         = 33;
  localparam int unsigned V_TOTAL      = V_ACT + V_FP + V_SYNC + V_BP;
  localparam int unsigned V_SYNC_START = V_ACT + V_FP;
  localparam int unsigned V_SYNC_END   = V_SYNC_START + V_SYNC;

  localparam int unsigned CNT_W       = 10;
  localparam int unsigned FRAME_CNT_W = 16;

  typedef enum logic [1:0] {
    PhActive,
    PhFront,
    PhSync,
    PhBack
  } phase_e;

endpackage

// File: rtl/pix_tick_gen.sv
// Free-running clock divider: o_tick is high for one clk out of every DIV, on the last count.
module pix_tick_gen #(
  parameter int unsigned DIV = 4
) (
  input  logic i_clk,
  input  logic i_rst,
  output logic o_tick
);

  localparam int unsigned W = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [W-1:0] LastCnt = W'(DIV - 1);

  logic [W-1:0] r_div_cnt;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_div_cnt <= '0;
    end else if (o_tick) begin
      r_div_cnt <= '0;
    end else begin
      r_div_cnt <= r_div_cnt + 1'b1;
    end
  end

  assign o_tick = (r_div_cnt == LastCnt);

endmodule

// File: rtl/vga_timing_ctrl.sv
// VGA timing producer: pixel coordinates, valid, syncs and line/frame pulses from a divided clock.
// Optional frame counter port enabled by defining VGA_FRAME_CNT_EN.
module vga_timing_ctrl #(
  parameter int unsigned DIV    = vga_timing_pkg::DIV_DEFAULT,
  parameter int unsigned H_ACT  = vga_timing_pkg::H_ACT,
  parameter int unsigned H_FP   = vga_timing_pkg::H_FP,
  parameter int unsigned H_SYNC = vga_timing_pkg::H_SYNC,
  parameter int unsigned H_BP   = vga_timing_pkg::H_BP,
  parameter int unsigned V_ACT  = vga_timing_pkg::V_ACT,
  parameter int unsigned V_FP   = vga_timing_pkg::V_FP,
  parameter int unsigned V_SYNC = vga_timing_pkg::V_SYNC,
  parameter int unsigned V_BP   = vga_timing_pkg::V_BP
) (
  input  logic        i_clk,
  input  logic        i_rst,
  output logic        o_pclk_en,
  output logic [9:0]  o_h_cnt,
  output logic [9:0]  o_v_cnt,
  output logic        o_valid,
  output logic        o_hsync,
  output logic        o_vsync,
  output logic        o_line_start,
`ifdef VGA_FRAME_CNT_EN
  output logic        o_frame_start,
  output logic [15:0] o_frame_cnt
`else
  output logic        o_frame_start
`endif
);

  import vga_timing_pkg::*;

  localparam logic [9:0] HActEnd    = 10'(H_ACT);
  localparam logic [9:0] HSyncStart = 10'(H_ACT + H_FP);
  localparam logic [9:0] HSyncEnd   = 10'(H_ACT + H_FP + H_SYNC);
  localparam logic [9:0] HLast      = 10'(H_ACT + H_FP + H_SYNC + H_BP - 1);
  localparam logic [9:0] VActEnd    = 10'(V_ACT);
  localparam logic [9:0] VSyncStart = 10'(V_ACT + V_FP);
  localparam logic [9:0] VSyncEnd   = 10'(V_ACT + V_FP + V_SYNC);
  localparam logic [9:0] VLast      = 10'(V_ACT + V_FP + V_SYNC + V_BP - 1);

  logic       w_tick;
  logic       w_h_wrap;
  logic       w_v_wrap;
  logic [9:0] w_h_next;
  logic [9:0] w_v_next;
  phase_e     w_h_state_d;
  phase_e     w_v_state_d;

  logic [9:0] r_h_cnt;
  logic [9:0] r_v_cnt;
  phase_e     r_h_state;
  phase_e     r_v_state;
  logic       r_pclk_en;
  logic       r_valid;
  logic       r_hsync;
  logic       r_vsync;
  logic       r_line_start;
  logic       r_frame_start;

  pix_tick_gen #(
    .DIV (DIV)
  ) u_pix_tick_gen (
    .i_clk  (i_clk),
    .i_rst  (i_rst),
    .o_tick (w_tick)
  );

  assign w_h_wrap = (r_h_cnt == HLast);
  assign w_v_wrap = (r_v_cnt == VLast);
  assign w_h_next = w_h_wrap ? '0 : r_h_cnt + 10'd1;
  assign w_v_next = w_h_wrap ? (w_v_wrap ? '0 : r_v_cnt + 10'd1) : r_v_cnt;

  // Phase FSMs look at the coordinate being loaded so state and counter stay aligned.
  always_comb begin
    w_h_state_d = r_h_state;
    if (w_tick) begin
      unique case (r_h_state)
        PhActive: if (w_h_next == HActEnd)    w_h_state_d = PhFront;
        PhFront:  if (w_h_next == HSyncStart) w_h_state_d = PhSync;
        PhSync:   if (w_h_next == HSyncEnd)   w_h_state_d = PhBack;
        PhBack:   if (w_h_next == '0)         w_h_state_d = PhActive;
        default:                              w_h_state_d = PhBack;
      endcase
    end
  end

  always_comb begin
    w_v_state_d = r_v_state;
    if (w_tick && w_h_wrap) begin
      unique case (r_v_state)
        PhActive: if (w_v_next == VActEnd)    w_v_state_d = PhFront;
        PhFront:  if (w_v_next == VSyncStart) w_v_state_d = PhSync;
        PhSync:   if (w_v_next == VSyncEnd)   w_v_state_d = PhBack;
        PhBack:   if (w_v_next == '0)         w_v_state_d = PhActive;
        default:                              w_v_state_d = PhBack;
      endcase
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_h_cnt       <= HLast;
      r_v_cnt       <= VLast;
      r_h_state     <= PhBack;
      r_v_state     <= PhBack;
      r_pclk_en     <= 1'b0;
      r_valid       <= 1'b0;
      r_hsync       <= 1'b1;
      r_vsync       <= 1'b1;
      r_line_start  <= 1'b0;
      r_frame_start <= 1'b0;
    end else begin
      r_pclk_en     <= w_tick;
      r_line_start  <= w_tick & w_h_wrap;
      r_frame_start <= w_tick & w_h_wrap & w_v_wrap;
      r_h_state     <= w_h_state_d;
      r_v_state     <= w_v_state_d;
      r_valid       <= (w_h_state_d == PhActive) && (w_v_state_d == PhActive);
      r_hsync       <= (w_h_state_d != PhSync);
      r_vsync       <= (w_v_state_d != PhSync);
      if (w_tick) begin
        r_h_cnt <= w_h_next;
        r_v_cnt <= w_v_next;
      end
    end
  end

`ifdef VGA_FRAME_CNT_EN
  logic [15:0] r_frame_cnt;

  // Counts in the same clk that frame_start rises; wraps naturally at 16 bits.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_frame_cnt <= '0;
    end else if (w_tick && w_h_wrap && w_v_wrap) begin
      r_frame_cnt <= r_frame_cnt + 16'd1;
    end
  end

  assign o_frame_cnt = r_frame_cnt;
`endif

  assign o_pclk_en     = r_pclk_en;
  assign o_h_cnt       = r_h_cnt;
  assign o_v_cnt       = r_v_cnt;
  assign o_valid       = r_valid;
  assign o_hsync       = r_hsync;
  assign o_vsync       = r_vsync;
  assign o_line_start  = r_line_start;
  assign o_frame_start = r_frame_start;

endmodule

// File: tb/tb_vga_timing_ctrl.sv
// Scoreboard bench: full-size instance for line timing and reset, reduced geometry for frame timing.
module tb_vga_timing_ctrl;

  localparam int A_DIV = 4, A_HA = 640, A_HF = 16, A_HS = 96, A_HB = 48;
  localparam int A_VA = 480, A_VF = 10, A_VS = 2, A_VB = 33;
  localparam int B_DIV = 2, B_HA = 8, B_HF = 2, B_HS = 3, B_HB = 2;
  localparam int B_VA = 6, B_VF = 1, B_VS = 2, B_VB = 2;

  typedef struct {
    int cyc; int h; int v; int pe; int vld; int hs; int vs; int ls; int fs; int fc;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_a = 1'b1, rst_b = 1'b1;
  logic a_pe, a_vld, a_hs, a_vs, a_ls, a_fs;
  logic b_pe, b_vld, b_hs, b_vs, b_ls, b_fs;
  logic [9:0] a_h, a_v, b_h, b_v;
  int a_fc_i, b_fc_i;

  int cyc_a = -1, cyc_b = -1;
  int n_cmp = 0, n_bad = 0;
  exp_t q_a[$], q_b[$];
  exp_t last_a, last_b, hold_a, hold_b;

`ifdef VGA_FRAME_CNT_EN
  logic [15:0] a_fc, b_fc;
  assign a_fc_i = int'(a_fc);
  assign b_fc_i = int'(b_fc);
`else
  assign a_fc_i = 0;
  assign b_fc_i = 0;
`endif

  vga_timing_ctrl #(
    .DIV(A_DIV), .H_ACT(A_HA), .H_FP(A_HF), .H_SYNC(A_HS), .H_BP(A_HB),
    .V_ACT(A_VA), .V_FP(A_VF), .V_SYNC(A_VS), .V_BP(A_VB)
  ) dut_a (
    .i_clk(clk), .i_rst(rst_a), .o_pclk_en(a_pe), .o_h_cnt(a_h), .o_v_cnt(a_v),
    .o_valid(a_vld), .o_hsync(a_hs), .o_vsync(a_vs), .o_line_start(a_ls),
`ifdef VGA_FRAME_CNT_EN
    .o_frame_start(a_fs), .o_frame_cnt(a_fc)
`else
    .o_frame_start(a_fs)
`endif
  );

  vga_timing_ctrl #(
    .DIV(B_DIV), .H_ACT(B_HA), .H_FP(B_HF), .H_SYNC(B_HS), .H_BP(B_HB),
    .V_ACT(B_VA), .V_FP(B_VF), .V_SYNC(B_VS), .V_BP(B_VB)
  ) dut_b (
    .i_clk(clk), .i_rst(rst_b), .o_pclk_en(b_pe), .o_h_cnt(b_h), .o_v_cnt(b_v),
    .o_valid(b_vld), .o_hsync(b_hs), .o_vsync(b_vs), .o_line_start(b_ls),
`ifdef VGA_FRAME_CNT_EN
    .o_frame_start(b_fs), .o_frame_cnt(b_fc)
`else
    .o_frame_start(b_fs)
`endif
  );

  // Clocks since the last edge that sampled reset high.
  always @(posedge clk) begin
    cyc_a <= rst_a ? 0 : ((cyc_a < 0) ? -1 : cyc_a + 1);
    cyc_b <= rst_b ? 0 : ((cyc_b < 0) ? -1 : cyc_b + 1);
  end

  // Expected outputs for the k-th pixel tick after reset release.
  function automatic exp_t model(input int div, ha, hf, hs, hb, va, vf, vs, vb, k);
    exp_t m;
    int ht, vt;
    ht    = ha + hf + hs + hb;
    vt    = va + vf + vs + vb;
    m.cyc = div * (k + 1);
    m.h   = k % ht;
    m.v   = (k / ht) % vt;
    m.pe  = 1;
    m.vld = (m.h < ha && m.v < va) ? 1 : 0;
    m.hs  = (m.h >= ha + hf && m.h < ha + hf + hs) ? 0 : 1;
    m.vs  = (m.v >= va + vf && m.v < va + vf + vs) ? 0 : 1;
    m.ls  = (m.h == 0) ? 1 : 0;
    m.fs  = (m.h == 0 && m.v == 0) ? 1 : 0;
    m.fc  = (k / (ht * vt) + 1) % 65536;
    return m;
  endfunction

  function automatic exp_t reset_exp(input int ht, vt);
    exp_t m;
    m.cyc = 0; m.h = ht - 1; m.v = vt - 1; m.pe = 0; m.vld = 0;
    m.hs = 1; m.vs = 1; m.ls = 0; m.fs = 0; m.fc = 0;
    return m;
  endfunction

  task automatic cmp(input string nm, input int act, input int req);
    n_cmp++;
    if (act != req) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, req, $time);
    end
  endtask

  task automatic cmp_all(input string t, input exp_t e,
                         input int cyc, pe, h, v, vld, hs, vs, ls, fs, fc);
    if (e.pe != 0) cmp({t, "_cycle"}, cyc, e.cyc);
    cmp({t, "_pclk_en"}, pe, e.pe);
    cmp({t, "_h_cnt"}, h, e.h);
    cmp({t, "_v_cnt"}, v, e.v);
    cmp({t, "_valid"}, vld, e.vld);
    cmp({t, "_hsync"}, hs, e.hs);
    cmp({t, "_vsync"}, vs, e.vs);
    cmp({t, "_line_start"}, ls, e.ls);
    cmp({t, "_frame_start"}, fs, e.fs);
`ifdef VGA_FRAME_CNT_EN
    cmp({t, "_frame_cnt"}, fc, e.fc);
`endif
  endtask

  always @(negedge clk) begin
    if (cyc_a == 0) begin
      last_a = reset_exp(A_HA + A_HF + A_HS + A_HB, A_VA + A_VF + A_VS + A_VB);
      cmp_all("a_reset", last_a, cyc_a, int'(a_pe), int'(a_h), int'(a_v), int'(a_vld),
              int'(a_hs), int'(a_vs), int'(a_ls), int'(a_fs), a_fc_i);
    end else if (cyc_a > 0) begin
      if (a_pe) begin
        if (q_a.size() == 0) cmp("a_extra_tick", 1, 0);
        else begin
          last_a = q_a.pop_front();
          cmp_all("a_tick", last_a, cyc_a, int'(a_pe), int'(a_h), int'(a_v), int'(a_vld),
                  int'(a_hs), int'(a_vs), int'(a_ls), int'(a_fs), a_fc_i);
        end
      end else begin
        hold_a = last_a; hold_a.pe = 0; hold_a.ls = 0; hold_a.fs = 0;
        cmp_all("a_hold", hold_a, cyc_a, int'(a_pe), int'(a_h), int'(a_v), int'(a_vld),
                int'(a_hs), int'(a_vs), int'(a_ls), int'(a_fs), a_fc_i);
      end
    end
  end

  always @(negedge clk) begin
    if (cyc_b == 0) begin
      last_b = reset_exp(B_HA + B_HF + B_HS + B_HB, B_VA + B_VF + B_VS + B_VB);
      cmp_all("b_reset", last_b, cyc_b, int'(b_pe), int'(b_h), int'(b_v), int'(b_vld),
              int'(b_hs), int'(b_vs), int'(b_ls), int'(b_fs), b_fc_i);
    end else if (cyc_b > 0) begin
      if (b_pe) begin
        if (q_b.size() == 0) cmp("b_extra_tick", 1, 0);
        else begin
          last_b = q_b.pop_front();
          cmp_all("b_tick", last_b, cyc_b, int'(b_pe), int'(b_h), int'(b_v), int'(b_vld),
                  int'(b_hs), int'(b_vs), int'(b_ls), int'(b_fs), b_fc_i);
        end
      end else begin
        hold_b = last_b; hold_b.pe = 0; hold_b.ls = 0; hold_b.fs = 0;
        cmp_all("b_hold", hold_b, cyc_b, int'(b_pe), int'(b_h), int'(b_v), int'(b_vld),
                int'(b_hs), int'(b_vs), int'(b_ls), int'(b_fs), b_fc_i);
      end
    end
  end

  // Queue n ticks, release reset, then reassert for one edge right after the n-th tick.
  task automatic run_a(input int n);
    for (int k = 0; k < n; k++)
      q_a.push_back(model(A_DIV, A_HA, A_HF, A_HS, A_HB, A_VA, A_VF, A_VS, A_VB, k));
    rst_a = 1'b0;
    do @(negedge clk); while (cyc_a != A_DIV * n + 1);
    rst_a = 1'b1;
    @(negedge clk);
  endtask

  task automatic run_b(input int n);
    for (int k = 0; k < n; k++)
      q_b.push_back(model(B_DIV, B_HA, B_HF, B_HS, B_HB, B_VA, B_VF, B_VS, B_VB, k));
    rst_b = 1'b0;
    do @(negedge clk); while (cyc_b != B_DIV * n + 1);
    rst_b = 1'b1;
    @(negedge clk);
  endtask

  initial begin
    repeat (2) @(negedge clk);
    fork
      begin
        run_a(301);  // reset lands mid-line at h=300
        run_a(801);  // one full line plus the wrap into line 1
      end
      begin
        run_b(3 * 165 + 1);  // three frames plus the first tick of the fourth
      end
    join
    repeat (3) @(negedge clk);
    cmp("a_queue_drained", q_a.size(), 0);
    cmp("b_queue_drained", q_b.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
